fsqrt_issue_ctrl: RTL and testbench
===================================

Name: fsqrt_issue_ctrl

Overview:
- Issue/collect controller that sits directly around the fixed-latency, non-stallable fsqrt pipeline in the FPU.
- Accepts square-root requests over a valid/ready handshake and drives the operand into fsqrt.
- Tracks each in-flight op with a LATENCY-deep valid/tag delay line.
- Captures every fsqrt result into a DEPTH-entry result FIFO that feeds FPU writeback with backpressure.
- A credit rule guarantees a result never arrives at a full FIFO, because fsqrt cannot stall.

Parameters:
- LATENCY, 2: clock edges from operand presented on sq_x to valid result on sq_y; must be >= 1.
- DEPTH, 4: result FIFO entries; must be >= 2; any value is allowed, not only powers of two.
- TAG_W, 5: width of the destination-register tag carried with each op.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: request valid.
- in_ready, out, 1: request accepted when in_valid && in_ready (fire).
- in_x, in, 32: IEEE-754 single operand.
- in_tag, in, TAG_W: destination tag.
- sq_x, out, 32: operand to fsqrt x.
- sq_y, in, 32: fsqrt result y.
- out_valid, out, 1: FIFO head valid.
- out_ready, in, 1: writeback consumes the head when out_valid && out_ready (pop).
- out_data, out, 32: result at the FIFO head.
- out_tag, out, TAG_W: tag at the FIFO head.
- out_nv, out, 1: invalid-operation flag (see Optional Feature).

Behaviour:
- Reset (synchronous):
  - Clears vld_sr, tag_sr, rd_ptr, wr_ptr and count.
  - Outputs during and immediately after reset: in_ready=0 while rst=1; out_valid=0, out_data=0, out_tag=0, out_nv=0, sq_x=0.
- Operand path:
  - sq_x = in_x when fire, else 32'h0 (combinational).
- Delay line, per rising edge:
  - vld_sr[0] <= fire; tag_sr[0] <= in_tag.
  - Each stage i>0 takes stage i-1.
  - Entries in flight = popcount(vld_sr).
- Result capture:
  - When vld_sr[LATENCY-1]=1, sq_y is valid in that cycle.
  - At the next edge, {tag_sr[LATENCY-1], sq_y, nv} is written to mem[wr_ptr] and wr_ptr advances.
- Credits:
  - in_ready = !rst && (count + popcount(vld_sr) < DEPTH).
  - in_ready is a function of registers only; there is no combinational path from out_ready or in_valid to in_ready.
  - A pop frees a credit from the following cycle.
- Latency:
  - Fire at edge k places the result at the FIFO head after edge k+LATENCY.
  - With an empty FIFO, out_valid first rises LATENCY+1 cycles after the op was presented.
  - Throughput is one op per cycle while credits are available.
- FIFO:
  - out_valid = (count != 0).
  - out_data, out_tag and out_nv come from mem[rd_ptr], forced to 0 when out_valid=0.
  - Pointers wrap from DEPTH-1 to 0.
  - Push and pop in the same cycle leave count unchanged and move both pointers.
  - A push into an empty FIFO is visible on the next cycle only; there is no bypass.
  - A push into a full FIFO cannot occur. Verification asserts count + inflight <= DEPTH every cycle.
- Ordering: results leave strictly in issue order.
- Reset mid-operation:
  - In-flight ops and FIFO contents are discarded.
  - fsqrt outputs arriving after reset are ignored because vld_sr is cleared.
- Pop while out_valid=0: no effect.

Optional Feature:
- Macro: FSQRT_NV_FLAG_EN.
- Defined:
  - nv = in_x[31] && (in_x[30:0] != 0) && !(in_x[30:23]==8'hFF && in_x[22:0]!=0), i.e. negative nonzero, non-NaN operand.
  - nv is computed at fire, carried through a flag delay line alongside tag_sr, stored in the FIFO, and presented on out_nv.
- Not defined:
  - No flag storage.
  - out_nv is tied 0.
- The port exists in both builds.

Test Plan:
- Single op: DEPTH=4, LATENCY=2, in_x=32'h40800000, tag=5, out_ready=1 -> out_valid high exactly 3 cycles after fire, out_data=32'h40000000, out_tag=5, then out_valid=0.
- Back-to-back: 4 consecutive fires with x = 1.0, 4.0, 9.0, 16.0 (tags 1..4), out_ready=1 -> in_ready stays 1; results 1.0, 2.0, 3.0, 4.0 appear on 4 consecutive cycles in tag order.
- Backpressure: out_ready=0, in_valid held high -> exactly 4 ops accepted, then in_ready=0. Pulse out_ready for one cycle -> one pop; in_ready=1 on the next cycle; one more op accepted.
- Reset mid-flight: fire 2 ops, assert rst for 1 cycle on the following edge -> out_valid never rises for those ops; in_ready=0 during rst, 1 the cycle after; a new op completes normally.
- Wrap-around: 10 ops through DEPTH=4 with out_ready toggling every other cycle -> all 10 results in order, none lost or duplicated; the occupancy assertion holds throughout.
- Flag (macro defined): x=32'hC0800000 -> out_nv=1; x=32'h80000000 -> out_nv=0; x=32'hFFC00000 -> out_nv=0. Without the macro, all three give out_nv=0.

Source files
------------

// File: rtl/fsqrt_issue_ctrl.sv
// Issue/collect controller wrapped around the fixed-latency, non-stallable fsqrt pipeline.
// Optional invalid-operation flag path enabled by defining FSQRT_NV_FLAG_EN.
module fsqrt_issue_ctrl #(
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      sq_x,
   input  logic [31:0]      sq_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_nv
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + LATENCY + 1);

   logic [LATENCY-1:0] vld_sr;
   logic [TAG_W-1:0]   tag_sr [LATENCY];
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [CW-1:0]      count;
   logic [CW-1:0]      inflight;

   logic [31:0]        mem_data [DEPTH];
   logic [TAG_W-1:0]   mem_tag  [DEPTH];

   logic fire;
   logic push;
   logic pop;

   // Credits count both queued results and ops still inside fsqrt, so a result never meets a full FIFO.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + CW'(vld_sr[i]);
      end
   end

   assign in_ready  = !rst && ((count + inflight) < CW'(DEPTH));
   assign fire      = in_valid && in_ready;
   assign sq_x      = fire ? in_x : 32'h0;
   assign push      = vld_sr[LATENCY-1];
   assign out_valid = !rst && (count != '0);
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_sr <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_sr[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         vld_sr[0] <= fire;
         tag_sr[0] <= in_tag;
         for (int i = 1; i < LATENCY; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            tag_sr[i] <= tag_sr[i-1];
         end
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_data[wr_ptr] <= sq_y;
         mem_tag[wr_ptr]  <= tag_sr[LATENCY-1];
      end
   end

   assign out_data = out_valid ? mem_data[rd_ptr] : 32'h0;
   assign out_tag  = out_valid ? mem_tag[rd_ptr]  : '0;

`ifdef FSQRT_NV_FLAG_EN
   logic [LATENCY-1:0] nv_sr;
   logic               mem_nv [DEPTH];
   logic               nv_in;

   // Negative, nonzero and not a NaN: sqrt of it is an invalid operation.
   assign nv_in = in_x[31] && (in_x[30:0] != 31'h0) &&
                  !((in_x[30:23] == 8'hFF) && (in_x[22:0] != 23'h0));

   always_ff @(posedge clk) begin
      if (rst) begin
         nv_sr <= '0;
      end else begin
         nv_sr[0] <= fire && nv_in;
         for (int i = 1; i < LATENCY; i++) begin
            nv_sr[i] <= nv_sr[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_nv[wr_ptr] <= nv_sr[LATENCY-1];
      end
   end

   assign out_nv = out_valid ? mem_nv[rd_ptr] : 1'b0;
`else
   assign out_nv = 1'b0;
`endif

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Self-checking bench for fsqrt_issue_ctrl: directed test-plan steps plus random traffic
// compared against a queue model of issued ops and their arrival times.
module tb_fsqrt_issue_ctrl;

   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_x = 32'h0;
   logic [TAG_W-1:0] in_tag = '0;
   logic [31:0]      sq_x;
   logic [31:0]      sq_y;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_nv;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   fsqrt_issue_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_tag(in_tag), .sq_x(sq_x), .sq_y(sq_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_nv(out_nv)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f32(input int unsigned n);
      int p;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 32; i++) if (n[i]) p = i;
      m = n << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   // Stand-in fsqrt: exact on perfect squares, otherwise any deterministic mapping.
   function automatic logic [31:0] fsqrt_fn(input logic [31:0] x);
      for (int n = 0; n < 256; n++) if (f32(n * n) == x) return f32(n);
      return {1'b0, x[31:1]} ^ 32'h1234_5678;
   endfunction

   function automatic logic nv_fn(input logic [31:0] x);
`ifdef FSQRT_NV_FLAG_EN
      return x[31] && (x[30:0] != 31'h0) && !((x[30:23] == 8'hFF) && (x[22:0] != 23'h0));
`else
      return 1'b0;
`endif
   endfunction

   logic [31:0] pipe [LATENCY];
   initial for (int i = 0; i < LATENCY; i++) pipe[i] = 32'h0;
   always @(posedge clk) begin
      pipe[0] <= fsqrt_fn(sq_x);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
   end
   assign sq_y = pipe[LATENCY-1];

   typedef struct {
      logic [31:0]      d;
      logic [TAG_W-1:0] t;
      logic             nv;
      int               avail;
   } item_t;
   item_t q[$];

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h edge=%0d", name, obs, exp, edge_n);
      end
   endtask

   task automatic step();
      logic        exp_ready;
      logic        exp_valid;
      logic        fire;
      logic        occ_ok;
      logic [31:0] ed;
      logic [TAG_W-1:0] et;
      logic        env;
      item_t       it;
      @(negedge clk);
      exp_ready = !rst && (q.size() < DEPTH);
      exp_valid = !rst && (q.size() > 0) && (q[0].avail <= edge_n);
      ed = exp_valid ? q[0].d : 32'h0;
      et = exp_valid ? q[0].t : '0;
      env = exp_valid ? q[0].nv : 1'b0;
      fire = in_valid && exp_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out_data", out_data, ed);
      chk("out_tag", 32'(out_tag), 32'(et));
      chk("out_nv", 32'(out_nv), 32'(env));
      chk("sq_x", sq_x, fire ? in_x : 32'h0);
      occ_ok = (int'(dut.count) + int'(dut.inflight)) <= DEPTH;
      chk("occupancy", 32'(occ_ok), 32'd1);
      @(posedge clk);
      edge_n++;
      if (rst) begin
         q.delete();
      end else begin
         if (exp_valid && out_ready) void'(q.pop_front());
         if (fire) begin
            it.d = fsqrt_fn(in_x);
            it.t = in_tag;
            it.nv = nv_fn(in_x);
            it.avail = edge_n + LATENCY;
            q.push_back(it);
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] x, input logic [TAG_W-1:0] t,
                        input logic ordy, input logic r);
      in_valid = v; in_x = x; in_tag = t; out_ready = ordy; rst = r;
      step();
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, '0, ordy, 1'b0);
   endtask

   initial begin
      logic [31:0] rx;
      // reset
      drive(1'b0, 32'h0, '0, 1'b0, 1'b1);
      drive(1'b0, 32'h0, '0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // single op: sqrt(4.0) with tag 5
      drive(1'b1, 32'h4080_0000, 5'd5, 1'b1, 1'b0);
      idle(5, 1'b1);

      // back-to-back 1, 4, 9, 16
      for (int i = 1; i <= 4; i++) drive(1'b1, f32(i * i), 5'(i), 1'b1, 1'b0);
      idle(6, 1'b1);

      // backpressure: fill credits, then a single pop frees one more
      for (int i = 0; i < 7; i++) drive(1'b1, f32((i + 2) * (i + 2)), 5'(10 + i), 1'b0, 1'b0);
      drive(1'b1, f32(100), 5'd20, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, f32(121), 5'd21, 1'b0, 1'b0);
      idle(8, 1'b1);

      // reset while two ops are in flight
      drive(1'b1, f32(25), 5'd7, 1'b1, 1'b0);
      drive(1'b1, f32(36), 5'd8, 1'b1, 1'b0);
      drive(1'b0, 32'h0, '0, 1'b1, 1'b1);
      idle(4, 1'b1);
      drive(1'b1, f32(49), 5'd9, 1'b1, 1'b0);
      idle(5, 1'b1);

      // wrap-around: 10 ops with out_ready toggling
      begin
         int sent = 0;
         int cyc = 0;
         while (sent < 10 && cyc < 200) begin
            in_valid = 1'b1; in_x = f32((sent + 3) * (sent + 3)); in_tag = 5'(sent);
            out_ready = cyc[0]; rst = 1'b0;
            if (!rst && q.size() < DEPTH) sent++;
            step();
            cyc++;
         end
         chk("wrap_sent", 32'(sent), 32'd10);
      end
      idle(12, 1'b1);

      // invalid-operation flag operands
      drive(1'b1, 32'hC080_0000, 5'd1, 1'b1, 1'b0);
      drive(1'b1, 32'h8000_0000, 5'd2, 1'b1, 1'b0);
      drive(1'b1, 32'hFFC0_0000, 5'd3, 1'b1, 1'b0);
      idle(6, 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 0) rx = f32($urandom_range(0, 255) ** 2);
         else rx = $urandom;
         drive(1'($urandom_range(0, 3) != 0), rx, 5'($urandom), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 63) == 0));
      end

      // drain with a bounded budget
      begin
         int budget = 0;
         while (q.size() > 0 && budget < 50) begin
            idle(1, 1'b1);
            budget++;
         end
         chk("drain_empty", 32'(q.size()), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
